// File: rtl/cpu_control_fsm.sv
// Control unit for the 16-opcode ISA: FETCH/EXECUTE/MEM_WAIT/HALT sequencer driving
// datapath control lines, with a timed memory handshake and a retired-instruction counter.
module cpu_control_fsm #(
    parameter int RD_WIDTH    = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_WIDTH    = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           opcode,
    input  logic [RD_WIDTH-1:0]  Rd,
    input  logic                 mem_ready,
    input  logic                 resume,
    output logic [2:0]           FS,
    output logic [1:0]           PS,
    output logic                 MB,
    output logic [1:0]           resultSource,
    output logic                 RW,
    output logic                 MW,
    output logic [1:0]           BC,
    output logic                 IL,
    output logic                 mem_req,
    output logic                 EOE,
    output logic                 bus_error,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_EXECUTE  = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam logic [3:0] OP_LI  = 4'd8;
    localparam logic [3:0] OP_LW  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_BIZ = 4'd11;
    localparam logic [3:0] OP_BNZ = 4'd12;
    localparam logic [3:0] OP_JAL = 4'd13;
    localparam logic [3:0] OP_JMP = 4'd14;
    localparam logic [3:0] OP_JR  = 4'd15;

    // Last MEM_WAIT count before the bus error fires; unused when the timeout is disabled.
    localparam logic [TO_WIDTH-1:0] TO_LAST =
        TO_WIDTH'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [TO_WIDTH-1:0]    to_cnt_q, to_cnt_d;
    logic [CNT_WIDTH-1:0]   instret_q, instret_d;
    logic                   retire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            to_cnt_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        retire       = 1'b0;
        FS           = 3'd0;
        PS           = 2'd0;
        MB           = 1'b0;
        resultSource = 2'd0;
        RW           = 1'b0;
        MW           = 1'b0;
        BC           = 2'd3;
        IL           = 1'b0;
        mem_req      = 1'b0;
        EOE          = 1'b0;
        bus_error    = 1'b0;

        case (state_q)
            S_FETCH: begin
                IL      = 1'b1;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                retire  = 1'b1;
                if (!opcode[3]) begin
                    FS = opcode[2:0];
                    RW = 1'b1;
                    PS = 2'd1;
                end else begin
                    case (opcode)
                        OP_LI: begin
                            MB           = 1'b1;
                            resultSource = 2'd3;
                            RW           = 1'b1;
                            PS           = 2'd1;
                        end
                        OP_LW, OP_SW: begin
                            mem_req  = 1'b1;
                            retire   = 1'b0;
                            to_cnt_d = '0;
                            state_d  = S_MEM_WAIT;
                        end
                        OP_BIZ: begin
                            PS = 2'd2;
                            BC = 2'd0;
                        end
                        OP_BNZ: begin
                            PS = 2'd2;
                            BC = 2'd1;
                        end
                        OP_JAL: begin
                            PS           = 2'd2;
                            RW           = 1'b1;
                            resultSource = 2'd1;
                        end
                        OP_JMP: PS = 2'd2;
                        OP_JR: begin
                            if (Rd == '0) begin
                                PS = 2'd3;
                            end else if (Rd == '1) begin
                                retire  = 1'b0;
                                state_d = S_HALT;
                            end else begin
                                PS = 2'd1;
                            end
                        end
                        default: PS = 2'd1;
                    endcase
                end
            end
            S_MEM_WAIT: begin
                mem_req = 1'b1;
                // A ready arriving on the timeout cycle still completes the access.
                if (mem_ready) begin
                    if (opcode == OP_LW) begin
                        RW           = 1'b1;
                        resultSource = 2'd2;
                    end else begin
                        MW = 1'b1;
                    end
                    PS      = 2'd1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (MEM_TIMEOUT != 0 && to_cnt_q == TO_LAST) begin
                    bus_error = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_HALT: begin
                EOE = 1'b1;
                if (resume) begin
                    PS      = 2'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Datapath sees idle controls for the whole time reset is held.
        if (!reset) begin
            FS           = 3'd0;
            PS           = 2'd0;
            MB           = 1'b0;
            resultSource = 2'd0;
            RW           = 1'b0;
            MW           = 1'b0;
            BC           = 2'd3;
            IL           = 1'b0;
            mem_req      = 1'b0;
            EOE          = 1'b0;
            bus_error    = 1'b0;
        end

        instret_d = instret_q;
        if (retire && instret_q != '1) begin
            instret_d = instret_q + 1'b1;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: each scenario task drives vectors and compares the
// packed control bundle and instret against hand-derived values.
module tb_cpu_control_fsm;

    logic        clk;
    logic        reset;
    logic [3:0]  opcode;
    logic [3:0]  Rd;
    logic        mem_ready;
    logic        resume;
    logic [2:0]  FS;
    logic [1:0]  PS;
    logic        MB;
    logic [1:0]  resultSource;
    logic        RW;
    logic        MW;
    logic [1:0]  BC;
    logic        IL;
    logic        mem_req;
    logic        EOE;
    logic        bus_error;
    logic [15:0] instret;

    logic        reset_s;
    logic [3:0]  opcode_s;
    logic [2:0]  FS_s;
    logic [1:0]  PS_s, rs_s, BC_s;
    logic        MB_s, RW_s, MW_s, IL_s, mr_s, EOE_s, be_s;
    logic [3:0]  instret_s;

    int checks = 0;
    int errors = 0;

    cpu_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .Rd(Rd), .mem_ready(mem_ready),
        .resume(resume), .FS(FS), .PS(PS), .MB(MB), .resultSource(resultSource), .RW(RW),
        .MW(MW), .BC(BC), .IL(IL), .mem_req(mem_req), .EOE(EOE), .bus_error(bus_error),
        .instret(instret)
    );

    cpu_control_fsm #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset_s), .opcode(opcode_s), .Rd(4'd0), .mem_ready(1'b0),
        .resume(1'b0), .FS(FS_s), .PS(PS_s), .MB(MB_s), .resultSource(rs_s), .RW(RW_s),
        .MW(MW_s), .BC(BC_s), .IL(IL_s), .mem_req(mr_s), .EOE(EOE_s), .bus_error(be_s),
        .instret(instret_s)
    );

    wire [15:0] ctl_o = {FS, PS, MB, resultSource, RW, MW, BC, IL, mem_req, EOE, bus_error};

    // Expected bundle, argument order: fs ps mb rs rw mw bc il mem_req eoe bus_error.
    function automatic logic [15:0] ctl(int fs, int ps, int mb, int rs, int rw, int mw,
                                        int bc, int il, int mr, int eoe, int be);
        return {fs[2:0], ps[1:0], mb[0], rs[1:0], rw[0], mw[0], bc[1:0], il[0], mr[0],
                eoe[0], be[0]};
    endfunction

    localparam logic [15:0] C_IDLE  = {3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] C_FETCH = {3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; checks happen 1 ns later still.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; opcode = 4'd0; Rd = 4'd0; mem_ready = 1'b0; resume = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctl_o !== C_IDLE) begin
                errors++;
                $display("FAIL reset_outputs: ctl=%h expected %h", ctl_o, C_IDLE);
            end
            tick();
        end
        checks++;
        if (instret !== 16'd0) begin
            errors++;
            $display("FAIL reset_instret: instret=%0d expected 0", instret);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ctl_o !== C_FETCH) begin
            errors++;
            $display("FAIL first_fetch: ctl=%h expected %h", ctl_o, C_FETCH);
        end
        tick();
        checks++;
        if (ctl_o !== ctl(0, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL add_execute: ctl=%h expected %h", ctl_o, ctl(0, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0));
        end
        tick();
        checks++;
        if (instret !== 16'd1 || ctl_o !== C_FETCH) begin
            errors++;
            $display("FAIL add_retire: instret=%0d ctl=%h expected 1 and %h", instret, ctl_o, C_FETCH);
        end
    endtask

    task automatic test_alu_li();
        opcode = 4'd5;
        tick();
        checks++;
        if (ctl_o !== ctl(5, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL alu5_execute: ctl=%h expected %h", ctl_o, ctl(5, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0));
        end
        tick();
        opcode = 4'd8;
        tick();
        checks++;
        if (ctl_o !== ctl(0, 1, 1, 3, 1, 0, 3, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL li_execute: ctl=%h expected %h", ctl_o, ctl(0, 1, 1, 3, 1, 0, 3, 0, 0, 0, 0));
        end
        tick();
        checks++;
        if (instret !== 16'd3) begin
            errors++;
            $display("FAIL alu_li_instret: instret=%0d expected 3", instret);
        end
    endtask

    task automatic test_lw();
        int req_cycles = 0;
        opcode = 4'd9;
        tick();
        checks++;
        if (ctl_o !== ctl(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL lw_execute: ctl=%h expected %h", ctl_o, ctl(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0));
        end
        req_cycles += int'(mem_req);
        for (int i = 1; i <= 3; i++) begin
            tick();
            mem_ready = (i == 3);
            #1;
            req_cycles += int'(mem_req);
            if (i < 3) begin
                checks++;
                if (ctl_o !== ctl(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0)) begin
                    errors++;
                    $display("FAIL lw_wait%0d: ctl=%h expected %h", i, ctl_o, ctl(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0));
                end
            end
        end
        checks++;
        if (ctl_o !== ctl(0, 1, 0, 2, 1, 0, 3, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL lw_ready: ctl=%h expected %h", ctl_o, ctl(0, 1, 0, 2, 1, 0, 3, 0, 1, 0, 0));
        end
        tick();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (req_cycles != 4 || ctl_o !== C_FETCH || instret !== 16'd4) begin
            errors++;
            $display("FAIL lw_done: req_cycles=%0d ctl=%h instret=%0d expected 4 %h 4",
                     req_cycles, ctl_o, instret, C_FETCH);
        end
    endtask

    task automatic test_timeout();
        opcode = 4'd10;
        tick();
        tick();
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (MW !== 1'b0 || mem_req !== 1'b1 || bus_error !== (i == 16) || PS !== 2'd0) begin
                errors++;
                $display("FAIL sw_timeout_wait%0d: MW=%b mem_req=%b bus_error=%b PS=%0d expected 0 1 %0d 0",
                         i, MW, mem_req, bus_error, PS, (i == 16));
            end
            tick();
        end
        checks++;
        if (ctl_o !== ctl(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0) || instret !== 16'd4) begin
            errors++;
            $display("FAIL sw_timeout_halt: ctl=%h instret=%0d expected %h 4",
                     ctl_o, instret, ctl(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0));
        end
        resume = 1'b1;
        #1;
        checks++;
        if (ctl_o !== ctl(0, 1, 0, 0, 0, 0, 3, 0, 0, 1, 0)) begin
            errors++;
            $display("FAIL timeout_resume: ctl=%h expected %h", ctl_o, ctl(0, 1, 0, 0, 0, 0, 3, 0, 0, 1, 0));
        end
        tick();
        resume = 1'b0;
        #1;
        checks++;
        if (ctl_o !== C_FETCH || instret !== 16'd4) begin
            errors++;
            $display("FAIL timeout_refetch: ctl=%h instret=%0d expected %h 4", ctl_o, instret, C_FETCH);
        end
    endtask

    task automatic test_eoe();
        opcode = 4'd15; Rd = 4'hF;
        tick();
        checks++;
        if (ctl_o !== ctl(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL eoe_execute: ctl=%h expected %h", ctl_o, ctl(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            mem_ready = i[0];
            #1;
            checks++;
            if (ctl_o !== ctl(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0)) begin
                errors++;
                $display("FAIL eoe_halt%0d: ctl=%h expected %h", i, ctl_o, ctl(0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0));
            end
        end
        mem_ready = 1'b0;
        resume = 1'b1;
        #1;
        checks++;
        if (PS !== 2'd1 || EOE !== 1'b1) begin
            errors++;
            $display("FAIL eoe_resume: PS=%0d EOE=%b expected 1 1", PS, EOE);
        end
        tick();
        resume = 1'b0;
        #1;
        checks++;
        if (ctl_o !== C_FETCH || instret !== 16'd4) begin
            errors++;
            $display("FAIL eoe_refetch: ctl=%h instret=%0d expected %h 4", ctl_o, instret, C_FETCH);
        end
        Rd = 4'd0;
    endtask

    task automatic test_branch();
        opcode = 4'd11;
        tick();
        checks++;
        if (ctl_o !== ctl(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL biz_execute: ctl=%h expected %h", ctl_o, ctl(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        tick();
        opcode = 4'd12;
        #1;
        checks++;
        if (ctl_o !== C_FETCH) begin
            errors++;
            $display("FAIL bnz_fetch: ctl=%h expected %h", ctl_o, C_FETCH);
        end
        tick();
        checks++;
        if (ctl_o !== ctl(0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL bnz_execute: ctl=%h expected %h", ctl_o, ctl(0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        end
        tick();
        checks++;
        if (instret !== 16'd6) begin
            errors++;
            $display("FAIL branch_instret: instret=%0d expected 6", instret);
        end
    endtask

    task automatic test_jumps();
        opcode = 4'd13; resume = 1'b1;
        tick();
        resume = 1'b0;
        #1;
        checks++;
        if (ctl_o !== ctl(0, 2, 0, 1, 1, 0, 3, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL jal_execute: ctl=%h expected %h", ctl_o, ctl(0, 2, 0, 1, 1, 0, 3, 0, 0, 0, 0));
        end
        tick();
        opcode = 4'd14;
        tick();
        checks++;
        if (ctl_o !== ctl(0, 2, 0, 0, 0, 0, 3, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL jmp_execute: ctl=%h expected %h", ctl_o, ctl(0, 2, 0, 0, 0, 0, 3, 0, 0, 0, 0));
        end
        tick();
        opcode = 4'd15; Rd = 4'd0;
        tick();
        checks++;
        if (ctl_o !== ctl(0, 3, 0, 0, 0, 0, 3, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL jr_execute: ctl=%h expected %h", ctl_o, ctl(0, 3, 0, 0, 0, 0, 3, 0, 0, 0, 0));
        end
        tick();
        Rd = 4'd5;
        tick();
        checks++;
        if (ctl_o !== ctl(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL illegal_nop: ctl=%h expected %h", ctl_o, ctl(0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0));
        end
        tick();
        Rd = 4'd0;
        #1;
        checks++;
        if (ctl_o !== C_FETCH || instret !== 16'd10) begin
            errors++;
            $display("FAIL jumps_done: ctl=%h instret=%0d expected %h 10", ctl_o, instret, C_FETCH);
        end
    endtask

    task automatic test_reset_mem_wait();
        opcode = 4'd9;
        tick();
        tick();
        checks++;
        if (ctl_o !== ctl(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL rst_mw_wait: ctl=%h expected %h", ctl_o, ctl(0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0));
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ctl_o !== C_IDLE) begin
            errors++;
            $display("FAIL rst_mw_held: ctl=%h expected %h", ctl_o, C_IDLE);
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (ctl_o !== C_FETCH || instret !== 16'd0) begin
            errors++;
            $display("FAIL rst_mw_fetch: ctl=%h instret=%0d expected %h 0", ctl_o, instret, C_FETCH);
        end
        // Fresh access must get a full 16-cycle window, no early error.
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (bus_error !== 1'b0 || mem_req !== 1'b1) begin
                errors++;
                $display("FAIL rst_mw_window%0d: bus_error=%b mem_req=%b expected 0 1", i, bus_error, mem_req);
            end
        end
        tick();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (bus_error !== 1'b0 || RW !== 1'b1 || PS !== 2'd1) begin
            errors++;
            $display("FAIL ready_beats_timeout: bus_error=%b RW=%b PS=%0d expected 0 1 1", bus_error, RW, PS);
        end
        tick();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl_o !== C_FETCH || instret !== 16'd1) begin
            errors++;
            $display("FAIL ready_edge_done: ctl=%h instret=%0d expected %h 1", ctl_o, instret, C_FETCH);
        end
    endtask

    task automatic test_saturate();
        reset_s = 1'b0; opcode_s = 4'd0;
        tick();
        tick();
        reset_s = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            tick();
            if (i == 8 || i >= 15) begin
                checks++;
                if (instret_s !== ((i == 8) ? 4'd8 : 4'd15)) begin
                    errors++;
                    $display("FAIL sat_instret_op%0d: instret=%0d expected %0d", i, instret_s,
                             (i == 8) ? 8 : 15);
                end
            end
        end
    endtask

    initial begin
        reset_s = 1'b0; opcode_s = 4'd0;
        test_reset();
        test_alu_li();
        test_lw();
        test_timeout();
        test_eoe();
        test_branch();
        test_jumps();
        test_reset_mem_wait();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
